// File: rtl/audio_pkg.sv
// Shared definitions for the audio player: FSM encoding, audio_data field layout
// and the chromatic half-period table (24 MHz clock, index 1 = A4).
package audio_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_PLAY = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ENC_IDLE,
        ST_PLAY = ENC_PLAY,
        ST_DONE = ENC_DONE
    } state_t;

    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    // Half-period in clock cycles: round(12e6 / (440 * 2^((i-1)/12))); index 0 is a rest.
    localparam logic [15:0] NOTE_HALF [0:15] = '{
        16'd0,     16'd27273, 16'd25742, 16'd24297,
        16'd22934, 16'd21646, 16'd20431, 16'd19285,
        16'd18202, 16'd17181, 16'd16216, 16'd15306,
        16'd14447, 16'd13636, 16'd12871, 16'd12149
    };

endpackage

// File: rtl/audio_note_rom.sv
// Combinational lookup of a note index into its tone half-period in clock cycles.
module audio_note_rom
    import audio_pkg::*;
#(
    parameter int HALF_W = 16
) (
    input  logic [3:0]        i_index,
    output logic [HALF_W-1:0] o_half
);

    assign o_half = HALF_W'(NOTE_HALF[i_index]);

endmodule

// File: rtl/audio_player.sv
// Audio handshake responder: plays the latched note/duration byte as a square wave
// and pulses o_continue when it ends. Optional AUDIO_MUTE_EN adds a 'mute' input.
module audio_player
    import audio_pkg::*;
#(
    parameter int TICK_CYCLES = 1_200_000,
    parameter int HALF_W      = 16,
    parameter int TICK_W      = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audioreg,
    input  logic       audioact,
    input  logic [7:0] audio_data,
`ifdef AUDIO_MUTE_EN
    input  logic       mute,
`endif
    // The completion pulse is named o_continue because 'continue' is a reserved word.
    output logic       o_continue,
    output logic       speaker
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    state_t              r_state;
    logic [7:0]          r_note;
    logic [HALF_W-1:0]   r_half;
    logic [3:0]          r_dur;
    logic [TICK_W-1:0]   r_tick;
    logic [HALF_W-1:0]   r_tone;
    logic                r_rest;
    logic                r_speaker;
    logic                r_continue;

    state_t              w_state_next;
    logic [7:0]          w_note_next;
    logic [HALF_W-1:0]   w_half_next;
    logic [3:0]          w_dur_next;
    logic [TICK_W-1:0]   w_tick_next;
    logic [HALF_W-1:0]   w_tone_next;
    logic                w_rest_next;
    logic                w_speaker_next;
    logic                w_continue_next;

    logic [HALF_W-1:0]   w_rom_half;
    logic                w_mute;

`ifdef AUDIO_MUTE_EN
    assign w_mute = mute;
`else
    assign w_mute = 1'b0;
`endif

    audio_note_rom #(
        .HALF_W (HALF_W)
    ) u_note_rom (
        .i_index (r_note[NOTE_MSB:NOTE_LSB]),
        .o_half  (w_rom_half)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        w_state_next    = r_state;
        w_note_next     = r_note;
        w_half_next     = r_half;
        w_dur_next      = r_dur;
        w_tick_next     = r_tick;
        w_tone_next     = r_tone;
        w_rest_next     = r_rest;
        w_speaker_next  = r_speaker;
        w_continue_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_speaker_next = 1'b0;
                if (audioreg) begin
                    w_note_next = audio_data;
                end
                // A simultaneous load only affects the next request; this one uses r_note.
                if (audioact) begin
                    w_half_next = w_rom_half;
                    w_dur_next  = r_note[DUR_MSB:DUR_LSB];
                    w_tick_next = '0;
                    w_tone_next = w_rom_half;
                    w_rest_next = (r_note[NOTE_MSB:NOTE_LSB] == 4'd0);
                    if (r_note[DUR_MSB:DUR_LSB] == 4'd0) begin
                        w_state_next    = ST_DONE;
                        w_continue_next = 1'b1;
                    end else begin
                        w_state_next = ST_PLAY;
                    end
                end
            end

            ST_PLAY: begin
                if (!audioact) begin
                    w_state_next   = ST_IDLE;
                    w_speaker_next = 1'b0;
                end else begin
                    if (r_tick == TICK_LAST) begin
                        w_tick_next = '0;
                        w_dur_next  = r_dur - 4'd1;
                        if (r_dur == 4'd1) begin
                            w_state_next    = ST_DONE;
                            w_continue_next = 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick + 1'b1;
                    end

                    if (r_tone == HALF_W'(1)) begin
                        w_tone_next    = r_half;
                        w_speaker_next = r_rest ? 1'b0 : ~r_speaker;
                    end else begin
                        w_tone_next = r_tone - 1'b1;
                    end

                    if (w_mute) begin
                        w_speaker_next = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                w_speaker_next = 1'b0;
                w_state_next   = ST_IDLE;
            end

            default: begin
                w_state_next   = ST_IDLE;
                w_speaker_next = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_note     <= '0;
            r_half     <= '0;
            r_dur      <= '0;
            r_tick     <= '0;
            r_tone     <= '0;
            r_rest     <= 1'b0;
            r_speaker  <= 1'b0;
            r_continue <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_note     <= w_note_next;
            r_half     <= w_half_next;
            r_dur      <= w_dur_next;
            r_tick     <= w_tick_next;
            r_tone     <= w_tone_next;
            r_rest     <= w_rest_next;
            r_speaker  <= w_speaker_next;
            r_continue <= w_continue_next;
        end
    end

    assign o_continue = r_continue;
    assign speaker    = r_speaker;

endmodule
